// File: rtl/button_conditioner.sv
// Up/down push-button conditioner: 2-FF sync, debounce, press pulse and hold-to-repeat.
// Define BUTTON_CONDITIONER_AUTO_REPEAT_EN to build the DELAY/REPEAT auto-repeat machine.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 10_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic up_raw,
  input  logic down_raw,
  output logic up_pulse,
  output logic down_pulse,
  output logic up_held,
  output logic down_held
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DC_MAX = DW'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 2 || REPEAT_RATE_CYCLES < 2) begin : g_param_check
      $error("button_conditioner: cycle parameters must be >= 2");
    end
  endgenerate

  // Index 0 is the up channel, index 1 the down channel.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    s;
  logic [1:0]    held;
  logic [1:0]    held_nxt;
  logic [1:0]    pulse_nxt;
  logic [1:0]    pulse_q;
  logic [DW-1:0] dc     [2];
  logic [DW-1:0] dc_nxt [2];
  logic          both_nxt;

  assign raw = {down_raw, up_raw};

  always_comb begin
    for (int unsigned c = 0; c < 2; c++) begin
      held_nxt[c] = held[c];
      dc_nxt[c]   = '0;
      if (s[c] != held[c]) begin
        if (dc[c] == DC_MAX) begin
          held_nxt[c] = s[c];
        end else begin
          dc_nxt[c] = dc[c] + 1'b1;
        end
      end
    end
  end

  // Decisions use the held value being loaded this edge so the pulse lines up with held.
  assign both_nxt = &held_nxt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1   <= '0;
      s       <= '0;
      held    <= '0;
      pulse_q <= '0;
      for (int unsigned c = 0; c < 2; c++) begin
        dc[c] <= '0;
      end
    end else begin
      sync1   <= raw;
      s       <= sync1;
      held    <= held_nxt;
      pulse_q <= pulse_nxt;
      for (int unsigned c = 0; c < 2; c++) begin
        dc[c] <= dc_nxt[c];
      end
    end
  end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                 REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int unsigned RW = $clog2(RMAX);
  localparam logic [RW-1:0] RD_MAX = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RR_MAX = RW'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t        state     [2];
  state_t        state_nxt [2];
  logic [RW-1:0] rc        [2];
  logic [RW-1:0] rc_nxt    [2];

  always_comb begin
    for (int unsigned c = 0; c < 2; c++) begin
      state_nxt[c] = state[c];
      rc_nxt[c]    = rc[c];
      pulse_nxt[c] = 1'b0;
      if (!held_nxt[c] || both_nxt) begin
        state_nxt[c] = IDLE;
        rc_nxt[c]    = '0;
      end else begin
        case (state[c])
          IDLE: begin
            // Staying IDLE while held after a dual-press lockout blocks any pulse.
            if (!held[c]) begin
              pulse_nxt[c] = 1'b1;
              rc_nxt[c]    = '0;
              state_nxt[c] = DELAY;
            end
          end
          DELAY: begin
            if (rc[c] == RD_MAX) begin
              pulse_nxt[c] = 1'b1;
              rc_nxt[c]    = '0;
              state_nxt[c] = REPEAT;
            end else begin
              rc_nxt[c] = rc[c] + 1'b1;
            end
          end
          REPEAT: begin
            if (rc[c] == RR_MAX) begin
              pulse_nxt[c] = 1'b1;
              rc_nxt[c]    = '0;
            end else begin
              rc_nxt[c] = rc[c] + 1'b1;
            end
          end
          default: begin
            state_nxt[c] = IDLE;
            rc_nxt[c]    = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned c = 0; c < 2; c++) begin
        state[c] <= IDLE;
        rc[c]    <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < 2; c++) begin
        state[c] <= state_nxt[c];
        rc[c]    <= rc_nxt[c];
      end
    end
  end
`else
  assign pulse_nxt = held_nxt & ~held & ~{2{both_nxt}};
`endif

  assign up_pulse   = pulse_q[0];
  assign down_pulse = pulse_q[1];
  assign up_held    = held[0];
  assign down_held  = held[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_RATE=5.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic resetn;
  logic up_raw;
  logic down_raw;
  logic up_pulse;
  logic down_pulse;
  logic up_held;
  logic down_held;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  button_conditioner #(
    .DEBOUNCE_CYCLES    (4),
    .REPEAT_DELAY_CYCLES(20),
    .REPEAT_RATE_CYCLES (5)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .up_raw    (up_raw),
    .down_raw  (down_raw),
    .up_pulse  (up_pulse),
    .down_pulse(down_pulse),
    .up_held   (up_held),
    .down_held (down_held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed {uh,up,dh,dp}=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] obs();
    return {up_held, up_pulse, down_held, down_pulse};
  endfunction

  // Press pulse at tick p; repeats at p+20, then every 5, while t < stop.
  function automatic logic rep(input int t, input int p, input int stop);
    return (t == p) || (AR && t >= p + 20 && t < stop && ((t - p - 20) % 5 == 0));
  endfunction

  initial begin
    resetn   = 1'b0;
    up_raw   = 1'b0;
    down_raw = 1'b0;
    tick;
    tick;
    check("reset", obs(), 4'b0000);
    resetn = 1'b1;
    repeat (3) tick;
    check("idle", obs(), 4'b0000);

    // Clean press: raw high for 12 captures, held rises 5 edges after capture.
    for (int t = 1; t <= 24; t++) begin
      up_raw = (t <= 12);
      tick;
      check($sformatf("press t%0d", t), obs(),
            {(t >= 6 && t < 18), rep(t, 6, 18), 2'b00});
    end

    // Bounce shorter than the debounce window.
    for (int t = 1; t <= 14; t++) begin
      up_raw = (t <= 4) ? (t % 2 == 1) : 1'b0;
      tick;
      check($sformatf("bounce t%0d", t), obs(), 4'b0000);
    end
    repeat (4) tick;

    // Auto-repeat on down, held 60 cycles.
    for (int t = 1; t <= 72; t++) begin
      down_raw = (t <= 60);
      tick;
      check($sformatf("repeat t%0d", t), obs(),
            {2'b00, (t >= 6 && t < 66), rep(t, 6, 66)});
    end
    repeat (4) tick;

    // Simultaneous press, then release down only.
    for (int t = 1; t <= 56; t++) begin
      up_raw   = 1'b1;
      down_raw = (t <= 40);
      tick;
      check($sformatf("both t%0d", t), obs(),
            {(t >= 6), 1'b0, (t >= 6 && t < 46), 1'b0});
    end
    for (int t = 1; t <= 8; t++) begin
      up_raw = 1'b0;
      tick;
      check($sformatf("both_rel t%0d", t), obs(), {(t < 6), 3'b000});
    end
    repeat (4) tick;

    // Hold up into REPEAT, then reset with the button still pressed.
    for (int t = 1; t <= 30; t++) begin
      up_raw = 1'b1;
      tick;
      check($sformatf("hold t%0d", t), obs(), {(t >= 6), rep(t, 6, 1000), 2'b00});
    end
    resetn = 1'b0;
    tick;
    check("rst_edge", obs(), 4'b0000);
    tick;
    tick;
    resetn = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick;
      check($sformatf("post_rst t%0d", t), obs(), {(t >= 6), (t == 6), 2'b00});
    end
    up_raw = 1'b0;
    repeat (8) tick;
    check("final_idle", obs(), 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw up/down push-buttons of the alarm-set path into clean, clk-domain command pulses. Each of the two buttons goes through a 2-FF synchronizer, a counter-based debouncer, a press-edge pulse generator and a hold-to-repeat state machine. The block sits directly upstream of the alarm-time up/down counter and drives that counter's up/down inputs. All outputs are in the `clk` domain; the consumer must sample them on `clk`.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); must be ≥ 2.
- `REPEAT_DELAY_CYCLES`, default 50_000_000: cycles from the press pulse to the first repeat pulse; must be ≥ 2.
- `REPEAT_RATE_CYCLES`, default 10_000_000: cycles between subsequent repeat pulses; must be ≥ 2.
- `clk` input 1: system clock.
- `resetn` input 1: reset; one clock, reset is synchronous and active-low.
- `up_raw` input 1: asynchronous up button, active-high.
- `down_raw` input 1: asynchronous down button, active-high.
- `up_pulse` output 1: one-cycle up command.
- `down_pulse` output 1: one-cycle down command.
- `up_held` output 1: debounced up level.
- `down_held` output 1: debounced down level.

## Operation
- Two identical channels (up, down). Counter widths are `$clog2(param)` bits; counters saturate and never wrap.
- Synchronizer: two flops per channel. `s` is the second-stage output.
- Debouncer:
  - Counter `dc` increments every cycle that `s != held` and clears to 0 whenever `s == held`.
  - On the cycle `dc == DEBOUNCE_CYCLES-1` with `s != held` still true, `held <= s` and `dc <= 0`.
  - A glitch shorter than `DEBOUNCE_CYCLES` leaves `held` unchanged.
- Per-channel repeat FSM, states IDLE, DELAY, REPEAT, with counter `rc`:
  - IDLE: on the `held` rising edge, assert the press pulse, set `rc <= 0`, go to DELAY.
  - DELAY: `rc` increments each cycle. At `rc == REPEAT_DELAY_CYCLES-1`, assert a pulse, set `rc <= 0`, go to REPEAT.
  - REPEAT: `rc` increments each cycle. At `rc == REPEAT_RATE_CYCLES-1`, assert a pulse and set `rc <= 0`.
  - From any state, `held` low forces IDLE in that cycle with no pulse.
- Mutual exclusion:
  - While both `up_held` and `down_held` are 1, both `*_pulse` outputs are forced to 0.
  - Both FSMs are forced to IDLE while both are held.
  - After one button releases, the remaining held button generates no pulse until it is released and pressed again.
- Reset values: `up_pulse`, `down_pulse`, `up_held`, `down_held` = 0; synchronizer flops = 0; `dc` = `rc` = 0; FSMs = IDLE.
- Reset mid-operation discards all state. A button still physically pressed when `resetn` returns high is debounced as a fresh press and produces a press pulse.

## Timing
- Let a raw change first be captured at edge N. Then `s` changes at edge N+1, and `held` changes at edge N+1+`DEBOUNCE_CYCLES`.
- The press pulse is registered: `*_pulse` is high for exactly the one cycle in which `*_held` first reads 1.
- First repeat pulse: `REPEAT_DELAY_CYCLES` cycles after the press pulse.
- Subsequent repeat pulses: every `REPEAT_RATE_CYCLES` cycles.
- Pulses are never wider than one cycle. A channel never issues two pulses in adjacent cycles.
- Release: `held` falls `DEBOUNCE_CYCLES`+1 edges after raw falls. No pulse is issued in that cycle or after it.

## Configuration
- Macro: `BUTTON_CONDITIONER_AUTO_REPEAT_EN`.
- Defined: full IDLE/DELAY/REPEAT behaviour as above.
- Undefined:
  - The DELAY and REPEAT states and `rc` are not compiled.
  - Each press yields exactly one pulse, and holding produces nothing further.
  - `REPEAT_*` parameters are accepted but unused.
  - All other behaviour, including mutual exclusion, is unchanged.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY_CYCLES`=20, `REPEAT_RATE_CYCLES`=5.

- Clean press: `up_raw` rises before edge 10 and is held 12 cycles, then released -> `up_held`=1 at edge 15; one `up_pulse` at edge 15; `up_held`=0 at edge 27; `down_pulse` never asserts.
- Bounce: `up_raw` toggles 1,0,1,0 on consecutive cycles, then 0 -> `up_held` and `up_pulse` stay 0 throughout.
- Auto-repeat: `down_raw` held 60 cycles, press pulse at edge P -> `down_pulse` at P, P+20, P+25, P+30, … up to release; no pulse after `down_held` falls. With the macro undefined -> only the pulse at P.
- Simultaneous: `up_raw` and `down_raw` rise in the same cycle and are held 40 cycles -> no pulses, both `*_held`=1; release down only -> still no `up_pulse`.
- Reset mid-hold: `up` held, in REPEAT; `resetn`=0 for 3 cycles -> all outputs 0 at the first reset edge. With `up_raw` still high, release reset -> `up_held`=1 and `up_pulse` at the 6th edge after `resetn` returns to 1.
